fpu_op_sequencer: RTL and testbench
===================================

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 128, operand/result width (32, 64 or 128).
REQ-002 SHALL have parameter FPU_LATENCY, default 2, cycles from fpu_valid to a valid fpu_output/fpu_exeption (1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports req_valid, req_ready, input/output, 2, per-requester handshake (index 0, 1).
REQ-006 SHALL have ports req_operation, input, 2x2; req_inputA and req_inputB, input, 2xBIT_WIDTH; meaning per requester: op code (00 ADD, 01 SUB, 10 MUL, 11 DIV) and the two operands.
REQ-007 SHALL have ports fpu_valid, output, 1; fpu_operation, output, 2; fpu_inputA and fpu_inputB, output, BIT_WIDTH; meaning: issue to the FPU datapath.
REQ-008 SHALL have ports fpu_output, input, BIT_WIDTH, and fpu_exeption, input, 5 ([4] ovf, [3] unf, [2] div0, [1] invalid, [0] inexact); meaning: FPU result.
REQ-009 SHALL have ports rsp_valid, output, 1; rsp_ready, input, 1; rsp_id, output, 1 (requester index); rsp_result, output, BIT_WIDTH; rsp_exeption, output, 5; meaning: response channel.
REQ-010 SHALL have ports status_flags, output, 5 (sticky exceptions), and status_clear, input, 1 (clear them).

Function
REQ-011 SHALL run FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one operation in flight.
REQ-012 IDLE: SHALL grant round-robin among asserted req_valid; the last granted requester loses a tie; req_ready[i] high for one cycle only in the IDLE cycle granting i.
REQ-013 On grant SHALL latch id, op and operands; an unasserted req_valid is never granted.
REQ-014 ISSUE: SHALL assert fpu_valid for exactly one cycle with latched op/operands; fpu_inputA/B/operation held constant from ISSUE through RESP.
REQ-015 WAIT: SHALL count FPU_LATENCY cycles after ISSUE, then capture fpu_output and fpu_exeption into rsp_result/rsp_exeption.
REQ-016 Op 11 (DIV, not implemented in the datapath) SHALL skip ISSUE/WAIT: fpu_valid stays low; RESP gives result = sign 0, exponent all ones, mantissa MSB 1 and other bits 0 (quiet NaN); rsp_exeption = 00010, or 00110 if req_inputB == 0.
REQ-017 RESP: SHALL hold rsp_valid high with stable rsp_* until rsp_ready; on rsp_valid&&rsp_ready go to IDLE next cycle.
REQ-018 Requester-to-response latency (non-DIV, rsp_ready high) SHALL be FPU_LATENCY+2 cycles from grant; throughput one op per FPU_LATENCY+3 cycles.
REQ-019 New requests SHALL be ignored (req_ready low) outside IDLE.

Reset
REQ-020 While rst is high SHALL force state IDLE, round-robin pointer to requester 1 (so requester 0 wins first tie), and all of req_ready, fpu_valid, rsp_valid, status_flags, fpu_*, rsp_* low/zero.
REQ-021 Reset mid-operation SHALL abandon it without a response; FPU results arriving later SHALL be ignored.

Configuration
REQ-022 With macro FPU_SEQ_STICKY_STATUS_EN defined: status_flags |= rsp_exeption on each response handshake; status_clear zeroes the flags; a simultaneous clear and handshake leaves exactly that response's flags.
REQ-023 Without FPU_SEQ_STICKY_STATUS_EN: status_flags SHALL be constant 0 and status_clear ignored.

Structure
REQ-024 Shared package fpu_pkg SHALL hold op-code constants, exception bit indices, the FSM state encoding and the EXP/SGN width derivation from BIT_WIDTH.
REQ-025 The round-robin grant logic SHALL be a sub-module fpu_rr_arbiter (2 requesters, registered pointer).

Verification
REQ-026 BIT_WIDTH=32, LATENCY=2: req0 ADD 3F800000+40000000, FPU model returns 40400000/00000 -> rsp_id 0, rsp_result 40400000, rsp_valid 4 cycles after grant.
REQ-027 Both requesters valid every cycle after reset: grants SHALL alternate 0,1,0,1 for 4 ops.
REQ-028 req1 DIV with B=00000000 -> no fpu_valid, rsp_result 7FC00000, rsp_exeption 00110.
REQ-029 rsp_ready low 5 cycles in RESP -> rsp_* stable, no grant, req_ready low throughout.
REQ-030 With STICKY_EN: responses 00001 then 10001 -> status_flags 10001; status_clear with a 01000 response in the same cycle -> status_flags 01000.
REQ-031 rst pulsed during WAIT -> next cycle all outputs zero, no response for the abandoned op.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants for the FPU operation sequencer: op codes, exception bit
// positions, sequencer state encoding and float-format field widths.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int EXC_W    = 5;
  localparam int EXC_OVF  = 4;
  localparam int EXC_UNF  = 3;
  localparam int EXC_DIV0 = 2;
  localparam int EXC_INV  = 1;
  localparam int EXC_INX  = 0;

  localparam int SGN_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Exponent width of the IEEE binary32/64/128 format selected by bw.
  function automatic int exp_w(input int bw);
    case (bw)
      32:      return 8;
      64:      return 11;
      default: return 15;
    endcase
  endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer remembers the last winner,
// which loses the next tie.
module fpu_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_vld = en && (req != 2'b00);
    gnt_id  = (req == 2'b11) ? ~ptr_q : req[1];
    ptr_d   = gnt_vld ? gnt_id : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Serialises two requesters onto one fixed-latency FPU datapath, one op in flight.
// Optional sticky exception status: define FPU_SEQ_STICKY_STATUS_EN.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int BIT_WIDTH   = 128,
  parameter int FPU_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0][1:0]           req_operation,
  input  logic [1:0][BIT_WIDTH-1:0] req_inputA,
  input  logic [1:0][BIT_WIDTH-1:0] req_inputB,
  output logic                      fpu_valid,
  output logic [1:0]                fpu_operation,
  output logic [BIT_WIDTH-1:0]      fpu_inputA,
  output logic [BIT_WIDTH-1:0]      fpu_inputB,
  input  logic [BIT_WIDTH-1:0]      fpu_output,
  input  logic [EXC_W-1:0]          fpu_exeption,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [BIT_WIDTH-1:0]      rsp_result,
  output logic [EXC_W-1:0]          rsp_exeption,
  output logic [EXC_W-1:0]          status_flags,
  input  logic                      status_clear
);

  localparam int EXP_W = exp_w(BIT_WIDTH);
  localparam int MAN_W = BIT_WIDTH - SGN_W - EXP_W;
  localparam logic [BIT_WIDTH-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  seq_state_e           state_q, state_d;
  logic                 id_q, id_d;
  logic [1:0]           op_q, op_d;
  logic [BIT_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] res_q, res_d;
  logic [EXC_W-1:0]     exc_q, exc_d;
  logic [EXC_W-1:0]     flags_q, flags_d;
  logic                 fpu_valid_q, fpu_valid_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 gnt_vld, gnt_id;

  fpu_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (state_q == ST_IDLE && !rst),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    exc_d     = exc_q;
    req_ready = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_id] = 1'b1;
          id_d = gnt_id;
          op_d = req_operation[gnt_id];
          a_d  = req_inputA[gnt_id];
          b_d  = req_inputB[gnt_id];
          // DIV has no datapath: answer with a quiet NaN straight away
          if (req_operation[gnt_id] == OP_DIV) begin
            state_d         = ST_RESP;
            res_d           = QNAN;
            exc_d           = '0;
            exc_d[EXC_INV]  = 1'b1;
            exc_d[EXC_DIV0] = (req_inputB[gnt_id] == '0);
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = 4'(FPU_LATENCY - 1);
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          res_d   = fpu_output;
          exc_d   = fpu_exeption;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    fpu_valid_d = (state_d == ST_ISSUE);
    rsp_valid_d = (state_d == ST_RESP);
  end

`ifdef FPU_SEQ_STICKY_STATUS_EN
  always_comb begin
    flags_d = status_clear ? '0 : flags_q;
    if (rsp_valid_q && rsp_ready) flags_d = flags_d | exc_q;
  end
`else
  logic status_clear_unused;
  assign status_clear_unused = status_clear;
  always_comb flags_d = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      id_q        <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= 4'd0;
      res_q       <= '0;
      exc_q       <= '0;
      flags_q     <= '0;
      fpu_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      exc_q       <= exc_d;
      flags_q     <= flags_d;
      fpu_valid_q <= fpu_valid_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign fpu_valid     = fpu_valid_q;
  assign fpu_operation = op_q;
  assign fpu_inputA    = a_q;
  assign fpu_inputB    = b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = id_q;
  assign rsp_result    = res_q;
  assign rsp_exeption  = exc_q;
  assign status_flags  = flags_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Randomised bench for fpu_op_sequencer: FPU datapath stand-in plus a
// transaction-level scoreboard, with directed scenarios up front.
module tb_fpu_op_sequencer;

  localparam int BW  = 32;
  localparam int LAT = 2;
`ifdef FPU_SEQ_STICKY_STATUS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][1:0]     req_operation;
  logic [1:0][BW-1:0]  req_inputA, req_inputB;
  logic                fpu_valid;
  logic [1:0]          fpu_operation;
  logic [BW-1:0]       fpu_inputA, fpu_inputB, fpu_output;
  logic [4:0]          fpu_exeption;
  logic                rsp_valid, rsp_ready, rsp_id;
  logic [BW-1:0]       rsp_result;
  logic [4:0]          rsp_exeption, status_flags;
  logic                status_clear;

  fpu_op_sequencer #(.BIT_WIDTH(BW), .FPU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_operation(req_operation), .req_inputA(req_inputA), .req_inputB(req_inputB),
    .fpu_valid(fpu_valid), .fpu_operation(fpu_operation), .fpu_inputA(fpu_inputA),
    .fpu_inputB(fpu_inputB), .fpu_output(fpu_output), .fpu_exeption(fpu_exeption),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_exeption(rsp_exeption),
    .status_flags(status_flags), .status_clear(status_clear)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FPU stand-in: arithmetic on the raw bit patterns, exceptions from operand bits
  function automatic logic [36:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      default: r = a * b;
    endcase
    return {a[4:0] ^ b[9:5] ^ {3'b000, op}, r};
  endfunction

  logic        force_en = 1'b0;
  logic [31:0] force_res = '0;
  logic [4:0]  force_exc = '0;

  logic        pv [LAT];
  logic [36:0] pd [LAT];
  logic [36:0] junk;
  initial for (int k = 0; k < LAT; k++) pv[k] = 1'b0;

  always @(posedge clk) begin
    pv[0] <= fpu_valid;
    pd[0] <= force_en ? {force_exc, force_res} : fpu_fn(fpu_operation, fpu_inputA, fpu_inputB);
    for (int k = 1; k < LAT; k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
    junk <= 37'({$urandom, $urandom});
  end
  // Result is only meaningful exactly LAT cycles after issue; junk otherwise
  assign {fpu_exeption, fpu_output} = pv[LAT-1] ? pd[LAT-1] : junk;

  // ---------------- scoreboard ----------------
  typedef struct { int id; logic [31:0] res; logic [4:0] exc; int lat; } rsp_t;
  rsp_t rsp_log[$];
  int   grant_log[$];

  int          cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  bit          m_busy = 0, m_last = 1, post_rst = 0, m_seen = 0;
  int          m_id, m_issue, m_rsp, m_gcyc, m_lat;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  logic [4:0]  m_exc, m_flags = '0;

  always @(negedge clk) begin
    bit rv, hs;
    int w;
    logic [36:0] f;
    if (rst) begin
      m_busy = 0; m_last = 1; m_flags = '0; post_rst = 1;
    end else begin
      if (post_rst) begin
        chk("rst_fpu_side", {fpu_valid, fpu_operation, fpu_inputA, fpu_inputB}, '0);
        chk("rst_rsp_side", {rsp_valid, rsp_id, rsp_exeption, rsp_result, status_flags}, '0);
        post_rst = 0;
      end
      if (!m_busy) begin
        w = -1;
        if (req_valid == 2'b11)  w = 1 - int'(m_last);
        else if (req_valid[0])   w = 0;
        else if (req_valid[1])   w = 1;
        chk("req_ready", req_ready, (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10));
        if (w >= 0) begin
          m_busy = 1; m_last = w[0]; m_id = w; m_seen = 0; m_gcyc = cyc_n;
          m_op = req_operation[w]; m_a = req_inputA[w]; m_b = req_inputB[w];
          grant_log.push_back(w);
          if (m_op == 2'b11) begin
            m_issue = -1; m_rsp = cyc_n + 1;
            m_res = 32'h7FC00000;
            m_exc = (m_b == 0) ? 5'b00110 : 5'b00010;
          end else begin
            m_issue = cyc_n + 1; m_rsp = cyc_n + LAT + 2;
            f = force_en ? {force_exc, force_res} : fpu_fn(m_op, m_a, m_b);
            {m_exc, m_res} = f;
          end
        end
      end else begin
        chk("req_ready_busy", req_ready, 2'b00);
      end
      chk("fpu_valid", fpu_valid, m_busy && cyc_n == m_issue);
      if (m_busy && m_issue >= 0 && cyc_n >= m_issue)
        chk("fpu_args", {fpu_operation, fpu_inputA, fpu_inputB}, {m_op, m_a, m_b});
      rv = m_busy && cyc_n >= m_rsp;
      chk("rsp_valid", rsp_valid, rv);
      if (rv) begin
        chk("rsp_data", {rsp_id, rsp_exeption, rsp_result}, {m_id[0], m_exc, m_res});
        if (!m_seen) begin m_seen = 1; m_lat = cyc_n - m_gcyc; end
      end
      chk("status_flags", status_flags, m_flags);
      hs = rv && rsp_ready;
      if (STICKY) begin
        if (status_clear) m_flags = '0;
        if (hs) m_flags = m_flags | m_exc;
      end
      if (hs) begin
        rsp_log.push_back('{m_id, rsp_result, rsp_exeption, m_lat});
        m_busy = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int g0;
    g0 = grant_log.size();
    req_operation[id] = op; req_inputA[id] = a; req_inputB[id] = b;
    req_valid[id] = 1'b1;
    for (int k = 0; k < 60 && grant_log.size() == g0; k++) step();
    req_valid = 2'b00;
    if (grant_log.size() == g0) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int r0);
    for (int k = 0; k < 60 && rsp_log.size() == r0; k++) step();
    if (rsp_log.size() == r0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_rsp_valid();
    for (int k = 0; k < 60 && !rsp_valid; k++) step();
    if (!rsp_valid) chk("rsp_valid_timeout", 0, 1);
  endtask

  initial begin
    int r0, g0, g1;
    logic [31:0] held;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1; status_clear = 1'b0;
    req_operation = '0; req_inputA = '0; req_inputB = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // ADD with a known FPU answer, latency from grant
    force_res = 32'h40400000; force_exc = 5'b00000; force_en = 1'b1;
    r0 = rsp_log.size();
    send(0, 2'b00, 32'h3F800000, 32'h40000000);
    wait_rsp(r0);
    force_en = 1'b0;
    if (rsp_log.size() > r0) begin
      chk("add_id", rsp_log[r0].id, 0);
      chk("add_result", rsp_log[r0].res, 32'h40400000);
      chk("add_exc", rsp_log[r0].exc, 5'b00000);
      chk("add_latency", rsp_log[r0].lat, LAT + 2);
    end

    // DIV by zero from requester 1
    r0 = rsp_log.size();
    send(1, 2'b11, 32'h12345678, 32'h00000000);
    wait_rsp(r0);
    if (rsp_log.size() > r0) begin
      chk("div_id", rsp_log[r0].id, 1);
      chk("div_result", rsp_log[r0].res, 32'h7FC00000);
      chk("div_exc", rsp_log[r0].exc, 5'b00110);
    end

    // both requesters always valid: grants alternate starting with 0
    g0 = grant_log.size();
    req_operation = {2'b01, 2'b00};
    req_inputA = {32'h11111111, 32'h22222222}; req_inputB = {32'h3, 32'h4};
    req_valid = 2'b11;
    for (int k = 0; k < 100 && grant_log.size() < g0 + 4; k++) step();
    req_valid = 2'b00;
    if (grant_log.size() < g0 + 4) chk("alt_timeout", 0, 1);
    else for (int k = 0; k < 4; k++) chk($sformatf("alt_grant%0d", k), grant_log[g0+k], k % 2);
    for (int k = 0; k < 40 && m_busy; k++) step();

    // back-pressure: rsp_ready low for 5 cycles in RESP
    rsp_ready = 1'b0;
    send(0, 2'b10, 32'h00000007, 32'h00000009);
    req_valid = 2'b11;
    wait_rsp_valid();
    held = rsp_result;
    g1 = grant_log.size();
    repeat (5) step();
    chk("bp_no_grant", grant_log.size(), g1);
    chk("bp_hold", {rsp_valid, rsp_result}, {1'b1, held});
    req_valid = 2'b00;
    r0 = rsp_log.size();
    rsp_ready = 1'b1;
    wait_rsp(r0);

    // sticky status accumulation, then clear racing a handshake
    status_clear = 1'b1; step(); status_clear = 1'b0;
    force_en = 1'b1; force_res = 32'h1;
    force_exc = 5'b00001; r0 = rsp_log.size(); send(0, 2'b00, 32'h5, 32'h6); wait_rsp(r0);
    force_exc = 5'b10001; r0 = rsp_log.size(); send(1, 2'b00, 32'h7, 32'h8); wait_rsp(r0);
    step();
    chk("sticky_or", status_flags, STICKY ? 5'b10001 : 5'b00000);
    force_exc = 5'b01000; rsp_ready = 1'b0;
    send(0, 2'b01, 32'h9, 32'hA);
    wait_rsp_valid();
    rsp_ready = 1'b1; status_clear = 1'b1;
    step();
    status_clear = 1'b0; force_en = 1'b0;
    chk("sticky_clear_hs", status_flags, STICKY ? 5'b01000 : 5'b00000);

    // reset during WAIT abandons the op
    step();
    r0 = rsp_log.size();
    send(0, 2'b00, 32'hAAAA0000, 32'h00005555);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_wait_out", {fpu_valid, rsp_valid, rsp_result, status_flags}, '0);
    repeat (10) step();
    chk("rst_no_rsp", rsp_log.size(), r0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        req_operation[i] = 2'($urandom);
        req_inputA[i] = $urandom;
        req_inputB[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      status_clear = ($urandom_range(0, 15) == 0);
      step();
    end
    req_valid = 2'b00; rsp_ready = 1'b1; status_clear = 1'b0;
    repeat (20) step();
    chk("drain_idle", m_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
